// File: rtl/dut_stim_sequencer.sv
// dut_stim_sequencer
//   Round-robin arbitrated write sequencer for the simple DUT. Each requester
//   offers one single-port write (port, value, hold). The granted command is
//   written into the matching DUT input register and held for 'hold' cycles.
//   All DUT outputs are then sampled and returned to the requester as a
//   one-cycle response.
//
// Ports
//   clk, rst            clock / asynchronous active-high reset
//   req_valid/ready     per-requester handshake (ready is one-hot or zero)
//   req_port/data/hold  per-requester command fields, packed NREQ-wide
//   i_*                 registered DUT inputs driven by the sequencer
//   o_*                 DUT outputs sampled at the end of a command
//   rsp_valid/id/data/flags  one-cycle response, flags={o_b1,o_b2,o_b8}
//   busy                registered, high whenever the FSM is not IDLE
module dut_stim_sequencer #(
    parameter int NREQ   = 4,
    parameter int HOLD_W = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*2-1:0]        req_port,
    input  logic [NREQ*32-1:0]       req_data,
    input  logic [NREQ*HOLD_W-1:0]   req_hold,
    output logic                     i_bitSignal1,
    output logic                     i_bitSignal2,
    output logic [31:0]              i_bit32Signal1,
    output logic [7:0]               i_bit8Signal2,
    input  logic                     o_bitSignal1,
    input  logic                     o_bitSignal2,
    input  logic [31:0]              o_bit32Signal1,
    input  logic [7:0]               o_bit8Signal2,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [31:0]              rsp_data,
    output logic [9:0]               rsp_flags,
    output logic                     busy
);

    typedef enum logic [1:0] {IDLE, APPLY, HOLD, SAMPLE} state_e;

    state_e              state_q;
    logic [IDW-1:0]      last_q;
    logic [IDW-1:0]      id_q;
    logic [1:0]          port_q;
    logic [31:0]         data_q;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   cnt_q;

    // Round-robin search starting just after the last granted requester.
    logic                win_found;
    logic [IDW-1:0]      win_idx;
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_q) + k) % NREQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_idx   = IDW'(idx);
            end
        end
    end

    // Ready is only offered while idle; gated by rst so it reads 0 in reset.
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == IDLE && win_found)
            req_ready[win_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_q         <= IDW'(NREQ - 1);
            id_q           <= '0;
            port_q         <= '0;
            data_q         <= '0;
            hold_q         <= '0;
            cnt_q          <= '0;
            i_bitSignal1   <= 1'b0;
            i_bitSignal2   <= 1'b0;
            i_bit32Signal1 <= '0;
            i_bit8Signal2  <= '0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_data       <= '0;
            rsp_flags      <= '0;
            busy           <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    // win_found implies req_valid & req_ready for win_idx.
                    if (win_found) begin
                        id_q    <= win_idx;
                        last_q  <= win_idx;
                        port_q  <= req_port[win_idx*2 +: 2];
                        data_q  <= req_data[win_idx*32 +: 32];
                        hold_q  <= req_hold[win_idx*HOLD_W +: HOLD_W];
                        busy    <= 1'b1;
                        state_q <= APPLY;
                    end
                end
                APPLY: begin
                    case (port_q)
                        2'd0:    i_bitSignal1   <= data_q[0];
                        2'd1:    i_bitSignal2   <= data_q[0];
                        2'd2:    i_bit32Signal1 <= data_q;
                        default: i_bit8Signal2  <= data_q[7:0];
                    endcase
                    cnt_q   <= hold_q;
                    state_q <= (hold_q != '0) ? HOLD : SAMPLE;
                end
                HOLD: begin
                    // Leaving on cnt==1 gives exactly 'hold' cycles here.
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == HOLD_W'(1))
                        state_q <= SAMPLE;
                end
                default: begin
                    rsp_valid <= 1'b1;
                    rsp_id    <= id_q;
                    rsp_data  <= o_bit32Signal1;
                    rsp_flags <= {o_bitSignal1, o_bitSignal2, o_bit8Signal2};
                    busy      <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dut_stim_sequencer.md
# dut_stim_sequencer

Arbitrated stimulus sequencer for the simple DUT. Up to NREQ requesters each issue single-port write commands (port select, value, hold time); a round-robin arbiter grants one command at a time, the sequencer drives the selected DUT input register, holds it for the requested number of cycles, then samples all DUT outputs and returns them to the granted requester. It sits between testbench agents and the DUT input/output pins, replacing direct, uncoordinated pin pokes.

## Interface
- NREQ, 4, number of requesters (2..8)
- HOLD_W, 8, width of the per-command hold counter
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  per-requester accept (at most one bit high)
- req_port  in  NREQ*2  per-requester port select: 0=i_bitSignal1, 1=i_bitSignal2, 2=i_bit32Signal1, 3=i_bit8Signal2
- req_data  in  NREQ*32  per-requester write value
- req_hold  in  NREQ*HOLD_W  cycles to hold before sampling outputs
- i_bitSignal1, i_bitSignal2  out  1 each  DUT inputs (registered)
- i_bit32Signal1  out  32  DUT input (registered)
- i_bit8Signal2  out  8  DUT input (registered)
- o_bitSignal1, o_bitSignal2  in  1 each  DUT outputs
- o_bit32Signal1  in  32  DUT output
- o_bit8Signal2  in  8  DUT output
- rsp_valid  out  1  one-cycle response pulse
- rsp_id  out  clog2(NREQ)  requester index of the response
- rsp_data  out  32  sampled o_bit32Signal1
- rsp_flags  out  10  sampled {o_bitSignal1, o_bitSignal2, o_bit8Signal2}
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, APPLY, HOLD, SAMPLE.
- IDLE: winner = first set req_valid bit searching from (last_grant+1) mod NREQ upward with wrap. req_ready[winner]=1 combinationally; all other bits 0. No valid -> req_ready all 0, stay IDLE.
- Accept = req_valid[g] & req_ready[g] at an edge: latch port, data, hold, id=g; last_grant<=g; -> APPLY.
- APPLY: at the edge, write the selected DUT input register; other three hold their value. Width rule: 1-bit ports take data[0], 8-bit takes data[7:0], 32-bit takes data[31:0]; upper bits ignored. Load counter=hold. -> HOLD if hold!=0, else SAMPLE.
- HOLD: counter decrements each edge; counter==1 -> SAMPLE. Exactly hold cycles spent in HOLD.
- SAMPLE: at the edge, load rsp_data, rsp_flags, rsp_id from current DUT outputs/latched id; rsp_valid<=1 for one cycle; -> IDLE.
- req_ready is 0 in APPLY, HOLD, SAMPLE. Requesters may drop req_valid without a grant; only current-cycle valids are arbitrated.
- DUT input registers persist across commands; only rst clears them.

## Timing
- Reset values: DUT inputs all 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_flags 0, busy 0, state IDLE, last_grant NREQ-1 (requester 0 wins first).
- Accept at edge E0 -> DUT input changes at E0+1 -> rsp_valid high in cycle after E0+2+hold.
- hold=0: outputs sampled one cycle after input change; hold=2^HOLD_W-1 is the maximum.
- Back-to-back: the rsp_valid cycle is an IDLE cycle; a new accept may occur at its closing edge. Peak throughput one command per hold+3 cycles.
- rst asserted mid-command: immediately aborts; no rsp_valid issued; all outputs return to reset values; in-flight command lost.
- busy is registered from state; high from E0 through the SAMPLE edge.

## Test plan
- Reset: rst pulse mid-HOLD with i_bit32Signal1 previously 0x1234 -> all DUT inputs 0, rsp_valid never pulses, req_ready resumes with requester 0 priority.
- Single write: req 0 port 2 data 0xDEADBEEF hold 3 -> i_bit32Signal1=0xDEADBEEF at E0+1, rsp_valid at E0+5 with rsp_id 0, rsp_data = DUT o_bit32Signal1 at sample.
- Width truncation: port 3 data 0xFFFFFFA5 -> i_bit8Signal2=0xA5; port 0 data 0x2 -> i_bitSignal1=0; other inputs unchanged.
- Round-robin: all four valid continuously, hold 0 -> grant order 0,1,2,3,0; each rsp_valid 3 cycles apart, rsp_id matches grant.
- Contention with withdrawal: req 1 and 3 valid, req 1 drops valid before grant -> req 3 granted, req_ready never two-hot.
- Max hold: hold 255 -> rsp_valid exactly 257 cycles after accept edge, busy high throughout.
